// File: rtl/bucket_rotator.sv
// rtl/bucket_rotator.sv - rotates a time-sliced bloom filter by zero-filling the oldest bucket
//
// Each update pulse from the bucket-age timer starts a sweep that writes zero to
// every word of the bucket after cur_bucket. When the last word is accepted the
// swept bucket becomes the insert bucket. One extra update is queued while a
// sweep runs; any further update is dropped and flagged.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   update       one-cycle rotate request
//   clr_valid    zero-write request (held until clr_ready)
//   clr_ready    memory accepts the write this cycle
//   clr_bucket   bucket being cleared
//   clr_addr     word address being cleared
//   cur_bucket   active insert bucket
//   busy         sweep (CLEAR or DONE) in progress
//   rot_done     one-cycle pulse when a rotation completes
//   overrun      one-cycle pulse when an update is dropped
//   rot_count    (ROTATE_STATS_EN only) completed rotations, wrapping
//   drop_count   (ROTATE_STATS_EN only) dropped updates, saturating
//
// Optional feature macro: ROTATE_STATS_EN adds the rot_count/drop_count counters.

module bucket_rotator #(
  parameter int NUM_BUCKETS = 4,
  parameter int ADDR_BITS   = 10,
  parameter int BUCKET_BITS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   update,
  output logic                   clr_valid,
  input  logic                   clr_ready,
  output logic [BUCKET_BITS-1:0] clr_bucket,
  output logic [ADDR_BITS-1:0]   clr_addr,
  output logic [BUCKET_BITS-1:0] cur_bucket,
  output logic                   busy,
  output logic                   rot_done,
  output logic                   overrun
`ifdef ROTATE_STATS_EN
  ,
  output logic [31:0]            rot_count,
  output logic [15:0]            drop_count
`endif
);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  localparam logic [BUCKET_BITS-1:0] LAST_BUCKET = BUCKET_BITS'(NUM_BUCKETS - 1);
  localparam logic [ADDR_BITS-1:0]   LAST_ADDR   = '1;

  state_t state;
  logic   pending;

  // Explicit compare so a non-power-of-2 bucket count never reaches an unused index.
  function automatic logic [BUCKET_BITS-1:0] next_bucket(input logic [BUCKET_BITS-1:0] b);
    return (b == LAST_BUCKET) ? '0 : b + BUCKET_BITS'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur_bucket <= '0;
      clr_bucket <= '0;
      clr_addr   <= '0;
      clr_valid  <= 1'b0;
      busy       <= 1'b0;
      rot_done   <= 1'b0;
      overrun    <= 1'b0;
      pending    <= 1'b0;
    end else begin
      rot_done <= 1'b0;
      overrun  <= 1'b0;
      case (state)
        IDLE: begin
          if (update || pending) begin
            state      <= CLEAR;
            clr_valid  <= 1'b1;
            busy       <= 1'b1;
            clr_bucket <= next_bucket(cur_bucket);
            clr_addr   <= '0;
            // A queued request is consumed here; a fresh update this cycle re-queues.
            pending    <= update && pending;
          end
        end
        CLEAR: begin
          if (clr_ready) begin
            // Address wraps to 0 naturally after the last word.
            clr_addr <= clr_addr + ADDR_BITS'(1);
            if (clr_addr == LAST_ADDR) begin
              state     <= DONE;
              clr_valid <= 1'b0;
              rot_done  <= 1'b1;
            end
          end
          if (update) begin
            if (pending) overrun <= 1'b1;
            else         pending <= 1'b1;
          end
        end
        DONE: begin
          // Inserts switch to the freshly cleared bucket only now.
          cur_bucket <= clr_bucket;
          pending    <= update;
          if (pending) begin
            state      <= CLEAR;
            clr_valid  <= 1'b1;
            clr_bucket <= next_bucket(clr_bucket);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          clr_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef ROTATE_STATS_EN
  // Counters follow the registered pulses, so they settle one cycle after them.
  always_ff @(posedge clk) begin
    if (reset) begin
      rot_count  <= '0;
      drop_count <= '0;
    end else begin
      if (rot_done) rot_count <= rot_count + 32'd1;
      if (overrun && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bucket_rotator.sv
// tb/tb_bucket_rotator.sv - self-checking bench for bucket_rotator
module tb_bucket_rotator;
  localparam int NB = 3;
  localparam int AB = 3;
  localparam int BB = 2;
  localparam int W  = 1 << AB;

  logic          clk = 1'b0;
  logic          reset, update, clr_ready;
  logic          clr_valid, busy, rot_done, overrun;
  logic [BB-1:0] clr_bucket, cur_bucket;
  logic [AB-1:0] clr_addr;
`ifdef ROTATE_STATS_EN
  logic [31:0]   rot_count;
  logic [15:0]   drop_count;
`endif

  bucket_rotator #(.NUM_BUCKETS(NB), .ADDR_BITS(AB), .BUCKET_BITS(BB)) dut (
    .clk(clk), .reset(reset), .update(update),
    .clr_valid(clr_valid), .clr_ready(clr_ready),
    .clr_bucket(clr_bucket), .clr_addr(clr_addr), .cur_bucket(cur_bucket),
    .busy(busy), .rot_done(rot_done), .overrun(overrun)
`ifdef ROTATE_STATS_EN
    , .rot_count(rot_count), .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 sweeping, 2 finishing; bucket math by modulo.
  int m_phase, m_cur, m_clr, m_addr, m_rotc, m_dropc;
  bit m_pend, m_rot, m_ovr;

  task automatic model_step(input bit upd, input bit rdy, input bit rst);
    int ph, cur, clr, addr;
    bit pend, rot, ovr;
    ph = m_phase; cur = m_cur; clr = m_clr; addr = m_addr; pend = m_pend;
    rot = 0; ovr = 0;
    if (rst) begin
      ph = 0; cur = 0; clr = 0; addr = 0; pend = 0;
      m_rotc = 0; m_dropc = 0;
    end else begin
      if (m_rot) m_rotc++;
      if (m_ovr && m_dropc < 65535) m_dropc++;
      case (m_phase)
        0: if (upd || m_pend) begin
             ph = 1; clr = (m_cur + 1) % NB; addr = 0; pend = upd && m_pend;
           end
        1: begin
             if (rdy) begin
               addr = (m_addr + 1) % W;
               if (m_addr == W - 1) begin ph = 2; rot = 1; end
             end
             if (upd) begin
               if (m_pend) ovr = 1; else pend = 1;
             end
           end
        default: begin
             cur = m_clr;
             if (m_pend) begin ph = 1; clr = (m_clr + 1) % NB; end
             else ph = 0;
             pend = upd;
           end
      endcase
    end
    m_phase = ph; m_cur = cur; m_clr = clr; m_addr = addr;
    m_pend = pend; m_rot = rot; m_ovr = ovr;
  endtask

  task automatic step(input bit upd, input bit rdy, input bit rst);
    logic [10:0] a, e;
    update = upd; clr_ready = rdy; reset = rst;
    @(posedge clk);
    #1;
    model_step(upd, rdy, rst);
    a = {clr_valid, busy, rot_done, overrun, cur_bucket, clr_bucket, clr_addr};
    e = {m_phase == 1, m_phase != 0, m_rot, m_ovr, BB'(m_cur), BB'(m_clr), AB'(m_addr)};
    chk("model", 64'(a), 64'(e));
`ifdef ROTATE_STATS_EN
    chk("rot_count", 64'(rot_count), 64'(32'(m_rotc)));
    chk("drop_count", 64'(drop_count), 64'(16'(m_dropc)));
`endif
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step(0, 1, 0);
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  typedef struct {
    bit upd; bit rdy;
    bit valid; int addr; int bucket; int cur; bit rot; bit busy;
  } vec_t;

  vec_t vecs[10];
  int   wrap_exp[4] = '{1, 2, 0, 1};

  initial begin
    int   wr[W];
    int   accepted, seen, nrot, k;
    bit   rdy, pv, chk_next;
    logic [AB-1:0] pa;
    logic [9:0] ea, ee;

    // Directed single sweep, ready held high, update in row 0.
    vecs[0] = '{1, 1, 1, 0, 1, 0, 0, 1};
    for (int i = 1; i < 8; i++) vecs[i] = '{0, 1, 1, i, 1, 0, 0, 1};
    vecs[8] = '{0, 1, 0, 0, 1, 0, 1, 1};
    vecs[9] = '{0, 1, 0, 0, 1, 1, 0, 0};

    update = 0; clr_ready = 0; reset = 1;
    step(0, 0, 1);
    step(0, 0, 1);
    chk("reset_valid", 64'(clr_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_cur", 64'(cur_bucket), 64'd0);
    chk("reset_addr", 64'(clr_addr), 64'd0);
    chk("reset_pulses", 64'({rot_done, overrun}), 64'd0);

    for (int i = 0; i < 100; i++) begin
      step(0, 1'($urandom_range(0, 1)), 0);
      chk("idle_quiet", 64'({clr_valid, busy, cur_bucket}), 64'd0);
    end

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].upd, vecs[i].rdy, 0);
      ea = {clr_valid, clr_addr, clr_bucket, cur_bucket, rot_done, busy};
      ee = {vecs[i].valid, AB'(vecs[i].addr), BB'(vecs[i].bucket), BB'(vecs[i].cur),
            vecs[i].rot, vecs[i].busy};
      chk($sformatf("vec%0d", i), 64'(ea), 64'(ee));
    end

    // Wrap with three buckets.
    step(0, 1, 1);
    for (int r = 0; r < 4; r++) begin
      step(1, 1, 0);
      step(0, 1, 0);
      wait_idle(50);
      chk($sformatf("wrap_cur%0d", r), 64'(cur_bucket), 64'(wrap_exp[r]));
    end

    // Stalled sweep with ready pattern 1,0,0,1.
    for (int i = 0; i < W; i++) wr[i] = 0;
    accepted = 0; seen = 0;
    step(1, 1, 0);
    for (k = 0; k < 100 && seen == 0; k++) begin
      rdy = (k % 4 == 0) || (k % 4 == 3);
      pv = clr_valid; pa = clr_addr;
      if (clr_valid && rdy) begin
        wr[clr_addr]++;
        accepted++;
      end
      step(0, rdy, 0);
      if (pv && !rdy) chk("stall_hold", 64'(clr_addr), 64'(pa));
      if (rot_done) begin
        seen = 1;
        chk("stall_rot_after_8", 64'(accepted), 64'(W));
      end
    end
    chk("stall_rot_seen", 64'(seen), 64'd1);
    for (int i = 0; i < W; i++) chk($sformatf("stall_write%0d", i), 64'(wr[i]), 64'd1);
    wait_idle(20);

    // Three updates in one sweep: queue one, drop two.
    step(0, 1, 1);
    step(1, 1, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    chk("ovr_first", 64'(overrun), 64'd0);
    step(0, 1, 0);
    step(1, 1, 0);
    chk("ovr_second", 64'(overrun), 64'd1);
    step(0, 1, 0);
    step(1, 1, 0);
    chk("ovr_third", 64'(overrun), 64'd1);
    nrot = 0; chk_next = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 0);
      if (chk_next) begin
        chk("ovr_straight_clear", 64'(clr_valid), 64'd1);
        chk_next = 0;
      end
      if (rot_done) begin
        nrot++;
        if (nrot == 1) chk_next = 1;
      end
    end
    chk("ovr_rot_total", 64'(nrot), 64'd2);
    chk("ovr_cur", 64'(cur_bucket), 64'd2);
`ifdef ROTATE_STATS_EN
    chk("ovr_drop_count", 64'(drop_count), 64'd2);
`endif

    // Reset in the middle of a sweep.
    step(1, 1, 0);
    for (k = 0; k < 20 && clr_addr != AB'(4); k++) step(0, 1, 0);
    chk("rst_mid_reached", 64'(clr_addr), 64'd4);
    step(0, 1, 1);
    chk("rst_mid_out", 64'({clr_valid, busy, cur_bucket, rot_done}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      chk("rst_mid_quiet", 64'({clr_valid, rot_done}), 64'd0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 999) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
